// File: rtl/aud_i2s_tx.sv
// ---------------------------------------------------------------------------
// aud_i2s_tx -- codec-side I2S serial transmitter (drives ADCDAT).
//
// Takes parallel stereo frames through a one-entry holding buffer and
// serializes them MSB first onto o_adcdat. The bit stream is delayed one BCLK
// from each LRCK transition, as the I2S format requires. LRCK is an input and
// is sampled in the BCLK domain.
//
// Parameters:
//   DATA_W   bits per channel word (MSB first)
//   UNDER_W  width of the saturating underrun counter
//
// Ports:
//   i_clk          BCLK, all logic on the rising edge
//   i_rst_n        synchronous active-low reset
//   i_lrck         LRCK: 0 = left slot, 1 = right slot
//   i_en           transmit enable
//   i_frame_valid  frame offered on i_left / i_right
//   i_left         left sample (two's complement)
//   i_right        right sample (two's complement)
//   i_pattern      (AUD_I2S_TX_PATTERN_EN only) load a counting test pattern
//   o_frame_ready  holding buffer empty, a frame can be accepted
//   o_adcdat       serial data
//   o_underrun     one-cycle pulse: left slot started with no frame buffered
//   o_under_cnt    saturating underrun count
//   o_busy         a word is being shifted out
//
// Build option: define AUD_I2S_TX_PATTERN_EN to add the i_pattern input and
// the internal pattern generator.
// ---------------------------------------------------------------------------
module aud_i2s_tx #(
  parameter int DATA_W  = 16,
  parameter int UNDER_W = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_lrck,
  input  logic               i_en,
  input  logic               i_frame_valid,
  input  logic [DATA_W-1:0]  i_left,
  input  logic [DATA_W-1:0]  i_right,
`ifdef AUD_I2S_TX_PATTERN_EN
  input  logic               i_pattern,
`endif
  output logic               o_frame_ready,
  output logic               o_adcdat,
  output logic               o_underrun,
  output logic [UNDER_W-1:0] o_under_cnt,
  output logic               o_busy
);

  localparam int CNT_W = $clog2(DATA_W + 1);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   bit_cnt, bit_cnt_nx;
  logic [DATA_W-1:0]  shreg, shreg_nx;
  logic               adcdat_nx;
  logic               busy_nx;

  logic               lrck_d;
  logic [DATA_W-1:0]  buf_l, buf_r;
  // Only the right word of the current frame needs storage: the left word is
  // launched straight from the buffer in the same cycle it would be copied.
  logic [DATA_W-1:0]  cur_r;

  logic               lrck_edge;
  logic               slot_start;
  logic               left_start;
  logic               right_start;
  logic               pat_load;
  logic               consume;
  logic               underflow;
  logic               accept;
  logic [DATA_W-1:0]  start_word;

`ifdef AUD_I2S_TX_PATTERN_EN
  logic [DATA_W-1:0]  pcnt;
`endif

  // -------------------------------------------------------------------------
  // Slot detection and frame selection
  // -------------------------------------------------------------------------
  assign lrck_edge   = (i_lrck != lrck_d);
  assign slot_start  = lrck_edge && i_en;
  assign left_start  = slot_start && !i_lrck;
  assign right_start = slot_start && i_lrck;
  assign accept      = i_frame_valid && o_frame_ready;

`ifdef AUD_I2S_TX_PATTERN_EN
  assign pat_load = left_start && i_pattern;
`else
  assign pat_load = 1'b0;
`endif

  assign consume   = left_start && !pat_load && !o_frame_ready;
  assign underflow = left_start && !pat_load && o_frame_ready;

  always_comb begin
    start_word = '0;
    if (right_start) begin
      start_word = cur_r;
    end else if (pat_load) begin
`ifdef AUD_I2S_TX_PATTERN_EN
      start_word = pcnt;
`endif
    end else if (consume) begin
      start_word = buf_l;
    end
  end

  // -------------------------------------------------------------------------
  // Serializer FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= S_IDLE;
      bit_cnt  <= '0;
      shreg    <= '0;
      o_adcdat <= 1'b0;
      o_busy   <= 1'b0;
    end else begin
      state    <= state_nx;
      bit_cnt  <= bit_cnt_nx;
      shreg    <= shreg_nx;
      o_adcdat <= adcdat_nx;
      o_busy   <= busy_nx;
    end
  end

  // -------------------------------------------------------------------------
  // Serializer FSM: next state and outputs
  // A slot start always wins over an in-flight word, which is how a short
  // slot truncates the previous word without carrying bits over.
  // -------------------------------------------------------------------------
  always_comb begin
    state_nx   = state;
    bit_cnt_nx = bit_cnt;
    shreg_nx   = shreg;
    adcdat_nx  = 1'b0;
    busy_nx    = 1'b0;

    if (!i_en) begin
      state_nx   = S_IDLE;
      bit_cnt_nx = '0;
    end else if (slot_start) begin
      state_nx   = S_SHIFT;
      adcdat_nx  = start_word[DATA_W-1];
      shreg_nx   = start_word << 1;
      bit_cnt_nx = CNT_W'(DATA_W - 1);
      busy_nx    = 1'b1;
    end else begin
      case (state)
        S_SHIFT: begin
          if (bit_cnt != '0) begin
            adcdat_nx  = shreg[DATA_W-1];
            shreg_nx   = shreg << 1;
            bit_cnt_nx = bit_cnt - CNT_W'(1);
            busy_nx    = 1'b1;
          end else begin
            state_nx = S_IDLE;
          end
        end
        default: begin
          state_nx = S_IDLE;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Holding buffer, current frame, underrun accounting
  // -------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      lrck_d        <= i_lrck;
      o_frame_ready <= 1'b1;
      buf_l         <= '0;
      buf_r         <= '0;
      cur_r         <= '0;
      o_underrun    <= 1'b0;
      o_under_cnt   <= '0;
    end else begin
      lrck_d     <= i_lrck;
      o_underrun <= 1'b0;

      // Accept and consume are mutually exclusive: accept needs an empty
      // buffer, consume needs a full one.
      if (accept) begin
        buf_l         <= i_left;
        buf_r         <= i_right;
        o_frame_ready <= 1'b0;
      end else if (consume) begin
        o_frame_ready <= 1'b1;
      end

      if (consume) begin
        cur_r <= buf_r;
      end else if (underflow) begin
        cur_r      <= '0;
        o_underrun <= 1'b1;
        if (o_under_cnt != '1) begin
          o_under_cnt <= o_under_cnt + UNDER_W'(1);
        end
      end
`ifdef AUD_I2S_TX_PATTERN_EN
      else if (pat_load) begin
        cur_r <= ~pcnt;
      end
`endif
    end
  end

`ifdef AUD_I2S_TX_PATTERN_EN
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      pcnt <= '0;
    end else if (pat_load) begin
      pcnt <= pcnt + DATA_W'(1);
    end
  end
`endif

endmodule

// File: doc/aud_i2s_tx.md
Name: aud_i2s_tx

Overview:
- Codec-side I2S serial transmitter. Drives ADCDAT toward the recorder path from parallel stereo frames.
- Serves as the synthesizable counterpart of the recorder's serial receiver. Used for on-board loopback and to replace random-bit stimulus with known sample streams.
- Runs on BCLK. LRCK is an input, sampled in the BCLK domain.

Parameters:
- DATA_W, 16, bits per channel word, MSB first.
- UNDER_W, 8, width of the saturating underrun counter.

Ports:
- i_clk  in  1  BCLK. All logic on rising edge.
- i_rst_n  in  1  synchronous active-low reset.
- i_lrck  in  1  LRCK. 0 = left channel, 1 = right channel.
- i_en  in  1  transmit enable.
- i_frame_valid  in  1  a frame is offered on i_left/i_right.
- i_left  in  DATA_W  left sample, two's complement.
- i_right  in  DATA_W  right sample, two's complement.
- o_frame_ready  out  1  frame buffer empty, can accept a frame.
- o_adcdat  out  1  serial data.
- o_underrun  out  1  one-cycle pulse when a left slot starts with no frame available.
- o_under_cnt  out  UNDER_W  saturating count of underruns.
- o_busy  out  1  currently shifting a word.

Behaviour:
- Reset (i_rst_n=0 at a rising edge) forces:
  - o_adcdat=0, o_frame_ready=1, o_underrun=0, o_under_cnt=0, o_busy=0.
  - lrck_d=current i_lrck, so no edge is detected on the first cycle after reset.
  - Buffer empty, current frame = 0, bit counter = 0.
- Frame buffer: one-entry holding register.
  - Accept when i_frame_valid && o_frame_ready at an edge. o_frame_ready drops the next cycle.
  - o_frame_ready = !buffer_full. It is registered and has no combinational path from i_frame_valid.
- Edge detect: lrck_d registers i_lrck every cycle. Edge n is the first rising edge at which i_lrck != lrck_d.
- Slot start at edge n:
  - Falling LRCK (new value 0), left slot:
    - Buffer full: current <= buffer, buffer empties, o_frame_ready=1 from edge n+1. This happens in the same cycle as any accept; an accept at edge n is only possible if the buffer was empty, so no conflict.
    - Buffer empty: current <= 0, o_underrun pulses high for the cycle after edge n, o_under_cnt += 1, saturating at all ones.
  - Rising LRCK (new value 1), right slot: the word is current.right. The buffer is untouched.
- Serialization (I2S, one-BCLK delay):
  - At edge n, o_adcdat <= word[DATA_W-1].
  - Edges n+1 .. n+DATA_W-1 drive bits DATA_W-2 .. 0.
  - From edge n+DATA_W until the next slot start, o_adcdat=0.
  - o_busy=1 from edge n through edge n+DATA_W-1.
  - Receiver samples each bit on the rising edge following launch.
- Short slot: an LRCK transition before the word finishes aborts it. The new slot starts at that edge per the rules above, with no partial-word carryover.
- Long slot (more BCLKs than DATA_W): zero-padding continues indefinitely.
- i_en=0:
  - o_adcdat=0, o_busy=0, and the bit counter clears.
  - No frame consumption and no underrun counting.
  - The buffer still accepts one frame.
  - Re-enable mid-slot: output stays 0 until the next LRCK edge.
- i_en rising takes effect at the next detected LRCK edge only. The first transmitted slot may be right (current frame = 0 after reset).
- Reset mid-word: output goes to 0 at the reset edge, the buffered frame is discarded, and the counter is cleared.

Optional Feature:
- Macro AUD_I2S_TX_PATTERN_EN.
- Defined:
  - Extra input i_pattern (1 bit).
  - When i_pattern=1 at a left-slot start, current is loaded with left=pcnt, right=~pcnt, where pcnt is an internal DATA_W counter (reset 0) that increments after each such load.
  - The buffer is neither consumed nor checked, and no underrun is flagged.
- Undefined: port absent, pattern logic absent, behaviour exactly as above.

Test Plan:
1. Reset, then offer frame L=16'hA5C3, R=16'h0F01 with 32 BCLK per LRCK half-period → left slot bits 1010010111000011 appear on edges n..n+15, right slot 0000111100000001, zeros elsewhere. o_frame_ready returns to 1 at the left start.
2. No frame offered for 3 left slots → o_underrun pulses 3 times, o_under_cnt=3, o_adcdat all 0. With UNDER_W=2 and 5 underruns → o_under_cnt sticks at 3.
3. LRCK half-period of 10 BCLK with DATA_W=16, L=16'hFFFF → 10 ones per left slot, then the right word starts immediately at the next edge with no leftover bits.
4. Two back-to-back frame offers with i_frame_valid held high → the first is accepted, the second is held until the next left start (o_frame_ready=0 meanwhile), and both are transmitted in order.
5. i_en dropped mid-word → o_adcdat=0 at the next edge. Re-enable mid-slot → stays 0 until the next LRCK edge, then resumes with the correct channel.
6. With AUD_I2S_TX_PATTERN_EN defined and i_pattern=1 → successive left words 0,1,2, and right words 16'hFFFF,16'hFFFE,16'hFFFD. o_under_cnt stays 0.
